// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: op codes, controller states and op-legality helper shared by
// the ALU arbitration controller and its round-robin arbiter.
package alu_ctrl_pkg;

  // ALUControl encodings understood by the shared ALU.
  typedef enum logic [3:0] {
    AND = 4'd0,
    OR  = 4'd1,
    ADD = 4'd2,
    INC = 4'd3,
    DEC = 4'd4,
    NOT = 4'd5,
    SUB = 4'd6,
    XOR = 4'd7,
    SHL = 4'd8,
    SHR = 4'd9
  } alu_op_e;

  // Controller sequencing: accept, drive the ALU for one cycle, return the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ctrl_state_e;

  // Highest legal ALUControl code; anything above is answered locally as an error.
  localparam logic [3:0] OP_MAX = 4'd9;

  // Flags returned for an illegal op: zero set (result forced to 0), no carry.
  localparam logic [1:0] FLAGS_ILLEGAL = 2'b10;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter. The grant is combinational from the
// request vector; the tie-break pointer lives here and flips to the other
// requester once the served request has completed.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic [1:0] gnt
);

  logic ptr;

  // Tie-break pointer: after a completed transaction, favour the other requester.
  // NOTE: clocked state is written with non-blocking (<=) so every flop samples
  // pre-edge values; rst is synchronous, so it is tested inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~served;
    end
  end

  // One-hot grant: a lone request wins outright, the pointer settles a tie.
  // NOTE: gnt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// alu_arbiter_ctrl: shares one external ALU between two requesters.
// A request is accepted in IDLE (req_ready is combinational), latched into hold
// registers that drive the ALU directly during EXEC, and the ALU result/flags are
// captured into a registered response held until the requester consumes it.
// Illegal op codes (> 9) skip the ALU and return result 0, flags 2'b10, err 1.
// Optional feature macro: ALU_CARRY_CHAIN_EN -- per-requester carry registers
// that can replace req_flag_in when req_chain is set at accept time.
module alu_arbiter_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int n = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0][3:0]     req_op,
  input  logic [1:0][n-1:0]   req_a,
  input  logic [1:0][n-1:0]   req_b,
  input  logic [1:0]          req_flag_in,
  input  logic [1:0]          req_chain,
  output logic [1:0]          resp_valid,
  input  logic [1:0]          resp_ready,
  output logic [n-1:0]        resp_result,
  output logic [1:0]          resp_flags,
  output logic                resp_err,
  output logic [n-1:0]        alu_a,
  output logic [n-1:0]        alu_b,
  output logic                alu_flag_in,
  output logic [3:0]          alu_control,
  input  logic [n-1:0]        alu_result,
  input  logic [1:0]          alu_flags
);

  ctrl_state_e  state;
  logic         gnt_idx;   // requester owning the transaction in flight
  alu_op_e      hold_op;
  logic [n-1:0] hold_a;
  logic [n-1:0] hold_b;
  logic         hold_fi;

  logic [1:0]   arb_req;
  logic [1:0]   arb_gnt;
  logic         accept;
  logic         acc_idx;
  logic [3:0]   acc_op;
  logic         acc_fi;
  logic         resp_hs;

  // Requests are only offered to the arbiter while idle, so req_ready is zero elsewhere.
  assign arb_req = (state == IDLE) ? req_valid : 2'b00;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (resp_hs),
    .served  (gnt_idx),
    .gnt     (arb_gnt)
  );

  assign req_ready = arb_gnt;
  assign accept    = |arb_gnt;
  assign acc_idx   = arb_gnt[1];
  assign acc_op    = req_op[acc_idx];

  // resp_valid[gnt_idx] is always high in RESP, so a stray resp_ready elsewhere is ignored.
  assign resp_hs = (state == RESP) && resp_ready[gnt_idx];

  // The hold registers are flops, so the ALU inputs change only on clock edges.
  assign alu_a       = hold_a;
  assign alu_b       = hold_b;
  assign alu_flag_in = hold_fi;
  assign alu_control = hold_op;

`ifdef ALU_CARRY_CHAIN_EN
  logic [1:0] carry;

  // Remember each requester's last returned carry so a follow-up op can chain it in.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry <= 2'b00;
    end else if (resp_hs) begin
      carry[gnt_idx] <= resp_flags[0];
    end
  end

  assign acc_fi = req_chain[acc_idx] ? carry[acc_idx] : req_flag_in[acc_idx];
`else
  logic unused_chain;

  assign unused_chain = ^req_chain;
  assign acc_fi       = req_flag_in[acc_idx];
`endif

  // Control FSM: accept -> drive ALU -> hold response until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt_idx     <= 1'b0;
      hold_op     <= AND;
      hold_a      <= '0;
      hold_b      <= '0;
      hold_fi     <= 1'b0;
      resp_valid  <= 2'b00;
      resp_result <= '0;
      resp_flags  <= 2'b00;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            gnt_idx <= acc_idx;
            if (op_is_legal(acc_op)) begin
              hold_op <= alu_op_e'(acc_op);
              hold_a  <= req_a[acc_idx];
              hold_b  <= req_b[acc_idx];
              hold_fi <= acc_fi;
              state   <= EXEC;
            end else begin
              // Answer locally; the ALU inputs keep their previous values.
              resp_valid  <= 2'b01 << acc_idx;
              resp_result <= '0;
              resp_flags  <= FLAGS_ILLEGAL;
              resp_err    <= 1'b1;
              state       <= RESP;
            end
          end
        end

        EXEC: begin
          resp_valid  <= 2'b01 << gnt_idx;
          resp_result <= alu_result;
          resp_flags  <= alu_flags;
          resp_err    <= 1'b0;
          state       <= RESP;
        end

        RESP: begin
          if (resp_hs) begin
            resp_valid <= 2'b00;
            state      <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
